// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Purpose  : IF-stage controller. Owns the PC, addresses the combinational |
// |            instruction memory, captures {PC, Instruction} into a small   |
// |            prefetch FIFO and presents the FIFO head over valid/ready.    |
// |            Handles EX branch redirects and faults on fetches past the    |
// |            end of instruction memory.                                    |
// | Ports    : clk, reset (sync, active-high)                                |
// |            Inst_Address/Instruction   - instruction memory interface     |
// |            Redirect_Valid/Target      - PC change request from EX        |
// |            IF_Valid/ID_Ready          - head handshake toward decode     |
// |            IF_Instruction/IF_PC       - FIFO head contents               |
// |            Fetch_Fault                - FAULT state with FIFO drained    |
// | Config   : FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect    |
// |            target faults instead of being silently aligned.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned MEM_BYTES = 16,
   parameter int unsigned DEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] Inst_Address,
   input  logic [31:0] Instruction,
   input  logic        Redirect_Valid,
   input  logic [63:0] Redirect_Target,
   output logic        IF_Valid,
   input  logic        ID_Ready,
   output logic [31:0] IF_Instruction,
   output logic [63:0] IF_PC,
   output logic        Fetch_Fault
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] c_DEPTH     = CW'(DEPTH);
   localparam logic [PW-1:0] c_LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [64:0]   c_MEM_LIMIT = 65'(MEM_BYTES);

   localparam logic [0:0] c_ST_RUN   = 1'b0;
   localparam logic [0:0] c_ST_FAULT = 1'b1;

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic [63:0]   r_pc;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [63:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_fifo_inst [DEPTH];

   logic          w_valid;
   logic          w_pop;
   logic          w_push;
   logic          w_room;
   logic          w_pc_legal;
   logic          w_tgt_legal;
   logic          w_redir_ok;
   logic [63:0]   w_redir_pc;

   // Range checks are done 65 bits wide so a PC near 2^64 cannot wrap
   // around into the legal window.
   assign w_pc_legal  = ({1'b0, r_pc} + 65'd3) < c_MEM_LIMIT;
   assign w_tgt_legal = ({1'b0, w_redir_pc} + 65'd3) < c_MEM_LIMIT;

`ifdef FETCH_ALIGN_CHECK_EN
   // Misaligned target is loaded as-is and parks the sequencer in FAULT.
   assign w_redir_pc = Redirect_Target;
   assign w_redir_ok = (Redirect_Target[1:0] == 2'b00) && w_tgt_legal;
`else
   assign w_redir_pc = Redirect_Target & ~64'h3;
   assign w_redir_ok = w_tgt_legal;
`endif

   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & ID_Ready;
   // A slot frees up either because the FIFO is not full or because the
   // head leaves on this same edge.
   assign w_room  = (r_count < c_DEPTH) | w_pop;
   assign w_push  = (r_state == c_ST_RUN) & w_pc_legal & ~Redirect_Valid & w_room;

   assign Inst_Address = r_pc;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (Redirect_Valid) begin
         w_state_nxt = w_redir_ok ? c_ST_RUN : c_ST_FAULT;
      end else if ((r_state == c_ST_RUN) && w_room && !w_pc_legal) begin
         // Fault only when a fetch is actually due; a full FIFO just stalls.
         w_state_nxt = c_ST_FAULT;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      IF_Valid       = w_valid;
      Fetch_Fault    = (r_state == c_ST_FAULT) && !w_valid;
      IF_PC          = '0;
      IF_Instruction = '0;
      if (w_valid) begin
         IF_PC          = r_fifo_pc[r_rd_ptr];
         IF_Instruction = r_fifo_inst[r_rd_ptr];
      end
   end

   // ---------------- PC, pointers and occupancy ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (Redirect_Valid) begin
         // Redirect flushes everything, including a head being accepted now.
         r_pc     <= w_redir_pc;
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) begin
            r_pc     <= r_pc + 64'd4;
            r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- FIFO storage (contents qualified by r_count) ----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_pc;
         r_fifo_inst[r_wr_ptr] <= Instruction;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                            |
// | Purpose  : Self-checking bench for fetch_sequencer with a 16-byte image. |
// |            Per-cycle vector table plus hand-written redirect/fault runs. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

   localparam logic [31:0] c_W0 = 32'h02853483;
   localparam logic [31:0] c_W4 = 32'h009A84B3;
   localparam logic [31:0] c_W8 = 32'h00148493;
   localparam logic [31:0] c_WC = 32'h02953423;

   logic        clk;
   logic        reset;
   logic [63:0] Inst_Address;
   logic [31:0] Instruction;
   logic        Redirect_Valid;
   logic [63:0] Redirect_Target;
   logic        IF_Valid;
   logic        ID_Ready;
   logic [31:0] IF_Instruction;
   logic [63:0] IF_PC;
   logic        Fetch_Fault;

   int n_vec;
   int n_miscompare;

   typedef struct {
      bit          rst;
      bit          rv;
      logic [63:0] tgt;
      bit          rdy;
      bit          e_valid;
      bit          chk_head;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
      bit          e_fault;
      logic [63:0] e_addr;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   fetch_sequencer #(
      .RESET_PC (64'h0),
      .MEM_BYTES(16),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Inst_Address   (Inst_Address),
      .Instruction    (Instruction),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_Target(Redirect_Target),
      .IF_Valid       (IF_Valid),
      .ID_Ready       (ID_Ready),
      .IF_Instruction (IF_Instruction),
      .IF_PC          (IF_PC),
      .Fetch_Fault    (Fetch_Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory image.
   always_comb begin
      Instruction = 32'h0;
      if (Inst_Address < 64'd16) begin
         case (Inst_Address[3:2])
            2'd0:    Instruction = c_W0;
            2'd1:    Instruction = c_W4;
            2'd2:    Instruction = c_W8;
            default: Instruction = c_WC;
         endcase
      end
   end

   task automatic add(input bit rst, input bit rv, input logic [63:0] tgt, input bit rdy,
                      input bit ev, input bit ch, input logic [63:0] pc,
                      input logic [31:0] inst, input bit ef, input logic [63:0] addr);
      vec_t v;
      v.rst = rst; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
      v.e_valid = ev; v.chk_head = ch; v.e_pc = pc; v.e_inst = inst;
      v.e_fault = ef; v.e_addr = addr;
      vecs.push_back(v);
   endtask

   task automatic check_vec(input vec_t e, input int idx);
      n_vec++;
      if (IF_Valid !== e.e_valid) begin
         n_miscompare++;
         $display("FAIL row %0d IF_Valid: got %0b want %0b", idx, IF_Valid, e.e_valid);
      end
      if (Fetch_Fault !== e.e_fault) begin
         n_miscompare++;
         $display("FAIL row %0d Fetch_Fault: got %0b want %0b", idx, Fetch_Fault, e.e_fault);
      end
      if (Inst_Address !== e.e_addr) begin
         n_miscompare++;
         $display("FAIL row %0d Inst_Address: got %h want %h", idx, Inst_Address, e.e_addr);
      end
      if (e.chk_head) begin
         if (IF_PC !== e.e_pc) begin
            n_miscompare++;
            $display("FAIL row %0d IF_PC: got %h want %h", idx, IF_PC, e.e_pc);
         end
         if (IF_Instruction !== e.e_inst) begin
            n_miscompare++;
            $display("FAIL row %0d IF_Instruction: got %h want %h", idx, IF_Instruction, e.e_inst);
         end
      end
   endtask

   initial begin
      vec_t got;
      bit   seen;
      n_vec = 0;
      n_miscompare = 0;

      //  rst rv tgt     rdy  valid chk pc      inst  fault addr
      // Streaming from reset, run off the end of memory.
      add(0, 0, 64'h0, 1,   0, 1, 64'h0, 32'h0, 0, 64'h0);
      add(0, 0, 64'h0, 1,   1, 1, 64'h0, c_W0,  0, 64'h4);
      add(0, 0, 64'h0, 1,   1, 1, 64'h4, c_W4,  0, 64'h8);
      add(0, 0, 64'h0, 1,   1, 1, 64'h8, c_W8,  0, 64'hC);
      add(0, 0, 64'h0, 1,   1, 1, 64'hC, c_WC,  0, 64'h10);
      // Drained in FAULT; redirect to 0 clears it.
      add(0, 1, 64'h0, 1,   0, 0, 64'h0, 32'h0, 1, 64'h10);
      // Backpressure for five cycles.
      add(0, 0, 64'h0, 0,   0, 0, 64'h0, 32'h0, 0, 64'h0);
      add(0, 0, 64'h0, 0,   1, 1, 64'h0, c_W0,  0, 64'h4);
      add(0, 0, 64'h0, 0,   1, 1, 64'h0, c_W0,  0, 64'h8);
      add(0, 0, 64'h0, 0,   1, 1, 64'h0, c_W0,  0, 64'h8);
      add(0, 0, 64'h0, 0,   1, 1, 64'h0, c_W0,  0, 64'h8);
      // Release: full FIFO pops and pushes on the same edge.
      add(0, 0, 64'h0, 1,   1, 1, 64'h0, c_W0,  0, 64'h8);
      add(0, 0, 64'h0, 1,   1, 1, 64'h4, c_W4,  0, 64'hC);
      // Redirect to 4 while head PC=8 is being accepted.
      add(0, 1, 64'h4, 1,   1, 1, 64'h8, c_W8,  0, 64'h10);
      add(0, 0, 64'h0, 1,   0, 0, 64'h0, 32'h0, 0, 64'h4);
      add(0, 0, 64'h0, 1,   1, 1, 64'h4, c_W4,  0, 64'h8);
      // Fill, then full with PC at end of memory: stall, not fault.
      add(0, 0, 64'h0, 0,   1, 1, 64'h8, c_W8,  0, 64'hC);
      add(0, 0, 64'h0, 0,   1, 1, 64'h8, c_W8,  0, 64'h10);
      // Reset together with a redirect while full.
      add(1, 1, 64'h8, 1,   1, 1, 64'h8, c_W8,  0, 64'h10);
      add(0, 0, 64'h0, 0,   0, 1, 64'h0, 32'h0, 0, 64'h0);
      add(0, 0, 64'h0, 1,   1, 1, 64'h0, c_W0,  0, 64'h4);
      // Misaligned redirect target 6.
      add(0, 1, 64'h6, 1,   1, 1, 64'h4, c_W4,  0, 64'h8);
`ifdef FETCH_ALIGN_CHECK_EN
      add(0, 0, 64'h0, 1,   0, 0, 64'h0, 32'h0, 1, 64'h6);
      add(0, 1, 64'h0, 1,   0, 0, 64'h0, 32'h0, 1, 64'h6);
`else
      add(0, 0, 64'h0, 1,   0, 0, 64'h0, 32'h0, 0, 64'h4);
      add(0, 1, 64'h0, 1,   1, 1, 64'h4, c_W4,  0, 64'h8);
`endif
      add(0, 0, 64'h0, 1,   0, 0, 64'h0, 32'h0, 0, 64'h0);

      reset = 1'b1;
      Redirect_Valid = 1'b0;
      Redirect_Target = 64'h0;
      ID_Ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset           = vecs[i].rst;
         Redirect_Valid  = vecs[i].rv;
         Redirect_Target = vecs[i].tgt;
         ID_Ready        = vecs[i].rdy;
         exp_q.push_back(vecs[i]);
         #1;
         got = exp_q.pop_front();
         check_vec(got, i);
      end

      // Redirect to the last word, then it must appear and be followed by FAULT.
      @(negedge clk);
      reset = 1'b0; Redirect_Valid = 1'b1; Redirect_Target = 64'hC; ID_Ready = 1'b1;
      @(negedge clk);
      Redirect_Valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (IF_Valid) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_miscompare++;
         $display("FAIL redirC IF_Valid: got 0 want 1 within 6 cycles");
      end else if (IF_PC !== 64'hC || IF_Instruction !== c_WC) begin
         n_miscompare++;
         $display("FAIL redirC head: got %h/%h want %h/%h", IF_PC, IF_Instruction, 64'hC, c_WC);
      end

      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (Fetch_Fault) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_miscompare++;
         $display("FAIL endfault Fetch_Fault: got 0 want 1 within 8 cycles");
      end else if (IF_Valid !== 1'b0 || Inst_Address !== 64'h10) begin
         n_miscompare++;
         $display("FAIL endfault state: got valid %0b addr %h want 0 / %h", IF_Valid, Inst_Address, 64'h10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule
`default_nettype wire
